// File: rtl/csa_addsub_pipe.sv
// Pipelined carry-select adder/subtractor with per-stage valid/ready handshake.
// Define CSA_SATURATE_EN to add the sat_en input and clamp the result on signed overflow.
module csa_addsub_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BLOCK  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic             cin,
`ifdef CSA_SATURATE_EN
    input  logic             sat_en,
`endif
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             is_not_equal,
    output logic             is_less_than
);

    localparam int unsigned NB  = WIDTH / BLOCK;
    localparam int unsigned SPS = (NB + STAGES - 1) / STAGES;

    // b holds the effective (already inverted for subtract) operand, so b[MSB] is sb'.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             sub;
        logic             sat;
        logic             ovf;
        logic             ne;
        logic             lt;
    } beat_t;

    beat_t             in_beat;
    beat_t             src_arr [STAGES+1];
    beat_t             st_d    [STAGES];
    beat_t             st_q    [STAGES];
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] load;
    logic [STAGES:0]   vchain;
    logic              rdy_run;
    logic              seg_c;
    logic              ovf_w;
    logic [BLOCK:0]    s0;
    logic [BLOCK:0]    s1;

    always_comb begin
        in_beat       = '0;
        in_beat.a     = data_a;
        in_beat.b     = op_sub ? ~data_b : data_b;
        in_beat.carry = op_sub | cin;
        in_beat.sub   = op_sub;
`ifdef CSA_SATURATE_EN
        in_beat.sat   = sat_en;
`endif
    end

    always_comb begin
        src_arr[0] = in_beat;
        for (int unsigned k = 0; k < STAGES; k++) begin
            src_arr[k+1] = st_q[k];
        end
    end

    // Ready ripples from the output back towards the input within the same cycle.
    always_comb begin
        rdy     = '0;
        rdy_run = out_ready;
        for (int unsigned j = 0; j < STAGES; j++) begin
            rdy_run            = ~v_q[STAGES-1-j] | rdy_run;
            rdy[STAGES-1-j]    = rdy_run;
        end
    end

    always_comb begin
        vchain = {v_q, in_valid};
        load   = '0;
        v_d    = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            load[k] = vchain[k] & rdy[k];
            v_d[k]  = rdy[k] ? vchain[k] : v_q[k];
        end
    end

    always_comb begin
        seg_c = 1'b0;
        ovf_w = 1'b0;
        s0    = '0;
        s1    = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            st_d[k] = src_arr[k];
            seg_c   = src_arr[k].carry;
            for (int unsigned s = 0; s < NB; s++) begin
                if (s >= k * SPS && s < (k + 1) * SPS) begin
                    s0 = {1'b0, src_arr[k].a[s*BLOCK +: BLOCK]} + {1'b0, src_arr[k].b[s*BLOCK +: BLOCK]};
                    s1 = {1'b0, src_arr[k].a[s*BLOCK +: BLOCK]} + {1'b0, src_arr[k].b[s*BLOCK +: BLOCK]}
                         + {{BLOCK{1'b0}}, 1'b1};
                    st_d[k].sum[s*BLOCK +: BLOCK] = seg_c ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
                    seg_c = seg_c ? s1[BLOCK] : s0[BLOCK];
                end
            end
            st_d[k].carry = seg_c;
            if (k == STAGES - 1) begin
                ovf_w = (src_arr[k].a[WIDTH-1] ^ src_arr[k].b[WIDTH-1]) ? 1'b0
                      : (st_d[k].sum[WIDTH-1] ^ src_arr[k].a[WIDTH-1]);
                st_d[k].ovf = ovf_w;
                st_d[k].lt  = src_arr[k].sub & (st_d[k].sum[WIDTH-1] ^ ovf_w);
                st_d[k].ne  = src_arr[k].sub & (|st_d[k].sum);
`ifdef CSA_SATURATE_EN
                // Clamp after the flags so they describe the unsaturated result.
                if (src_arr[k].sat && ovf_w) begin
                    st_d[k].sum = src_arr[k].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                        : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    st_q[k] <= st_d[k];
                end
            end
        end
    end

    assign in_ready     = rdy[0];
    assign out_valid    = v_q[STAGES-1];
    assign sum          = st_q[STAGES-1].sum;
    assign cout         = st_q[STAGES-1].carry;
    assign overflow     = st_q[STAGES-1].ovf;
    assign is_not_equal = st_q[STAGES-1].ne;
    assign is_less_than = st_q[STAGES-1].lt;

endmodule

// File: tb/tb_csa_addsub_pipe.sv
// Directed self-checking bench for csa_addsub_pipe; STAGES=1/4 copies check latency scaling.
module tb_csa_addsub_pipe;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         op_sub;
    logic         cin;
    logic         out_ready;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
`ifdef CSA_SATURATE_EN
    logic         sat_en;
`endif

    logic         rdy [3];
    logic         ov  [3];
    logic [W-1:0] sm  [3];
    logic         co  [3];
    logic         of  [3];
    logic         ne  [3];
    logic         lt  [3];

    int           checks = 0;
    int           errors = 0;

    int           lat   [3];
    logic         got_r [3];
    logic [W-1:0] r_sum [3];
    logic         r_co  [3];
    logic         r_of  [3];
    logic         r_ne  [3];
    logic         r_lt  [3];

    always #5 clock = ~clock;

    csa_addsub_pipe #(.WIDTH(32), .BLOCK(8), .STAGES(2)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .op_sub(op_sub), .cin(cin),
`ifdef CSA_SATURATE_EN
        .sat_en(sat_en),
`endif
        .data_a(data_a), .data_b(data_b), .out_valid(ov[0]), .out_ready(out_ready),
        .sum(sm[0]), .cout(co[0]), .overflow(of[0]), .is_not_equal(ne[0]), .is_less_than(lt[0])
    );

    csa_addsub_pipe #(.WIDTH(32), .BLOCK(8), .STAGES(1)) u_dut_s1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .op_sub(op_sub), .cin(cin),
`ifdef CSA_SATURATE_EN
        .sat_en(sat_en),
`endif
        .data_a(data_a), .data_b(data_b), .out_valid(ov[1]), .out_ready(out_ready),
        .sum(sm[1]), .cout(co[1]), .overflow(of[1]), .is_not_equal(ne[1]), .is_less_than(lt[1])
    );

    csa_addsub_pipe #(.WIDTH(32), .BLOCK(8), .STAGES(4)) u_dut_s4 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
        .op_sub(op_sub), .cin(cin),
`ifdef CSA_SATURATE_EN
        .sat_en(sat_en),
`endif
        .data_a(data_a), .data_b(data_b), .out_valid(ov[2]), .out_ready(out_ready),
        .sum(sm[2]), .cout(co[2]), .overflow(of[2]), .is_not_equal(ne[2]), .is_less_than(lt[2])
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge with every pipe idle and out_ready high.
    task automatic run_one(input logic sub, input logic ci, input logic [W-1:0] a, input logic [W-1:0] b);
        op_sub   = sub;
        cin      = ci;
        data_a   = a;
        data_b   = b;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        data_a   = 'x;
        data_b   = 'x;
        for (int d = 0; d < 3; d++) begin
            got_r[d] = 1'b0;
            lat[d]   = 0;
        end
        for (int cyc = 1; cyc <= 8; cyc++) begin
            for (int d = 0; d < 3; d++) begin
                if (!got_r[d] && ov[d]) begin
                    got_r[d] = 1'b1;
                    lat[d]   = cyc;
                    r_sum[d] = sm[d];
                    r_co[d]  = co[d];
                    r_of[d]  = of[d];
                    r_ne[d]  = ne[d];
                    r_lt[d]  = lt[d];
                end
            end
            if (got_r[0] && got_r[1] && got_r[2]) break;
            @(posedge clock); #1;
        end
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("result_seen_dut%0d", d), 32'(got_r[d]), 1);
        end
        @(posedge clock); #1;
    endtask

    logic [W-1:0] st_a   [4] = '{32'h1, 32'h10, 32'd100, 32'hFF};
    logic [W-1:0] st_b   [4] = '{32'h2, 32'h20, 32'd1,   32'h01};
    logic         st_sub [4] = '{1'b0,  1'b0,   1'b1,    1'b0};
    logic [W-1:0] st_exp [4] = '{32'h3, 32'h30, 32'h63,  32'h100};
    int           idx;
    int           ridx;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        cin       = 1'b0;
        data_a    = '0;
        data_b    = '0;
        out_ready = 1'b1;
`ifdef CSA_SATURATE_EN
        sat_en    = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check_eq("rst_out_valid", 32'(ov[0]), 0);
        check_eq("rst_sum",       sm[0],      0);
        check_eq("rst_cout",      32'(co[0]), 0);
        check_eq("rst_overflow",  32'(of[0]), 0);
        check_eq("rst_ne",        32'(ne[0]), 0);
        check_eq("rst_lt",        32'(lt[0]), 0);
        check_eq("rst_in_ready",  32'(rdy[0]), 1);

        run_one(1'b0, 1'b0, 32'h0000FFFF, 32'h00000001);
        check_eq("add_ffff_sum",  r_sum[0],      32'h00010000);
        check_eq("add_ffff_cout", 32'(r_co[0]),  0);
        check_eq("add_ffff_ovf",  32'(r_of[0]),  0);
        check_eq("add_ffff_ne",   32'(r_ne[0]),  0);
        check_eq("add_ffff_lt",   32'(r_lt[0]),  0);
        check_eq("add_ffff_lat",  lat[0],        2);

        run_one(1'b0, 1'b1, 32'd3, 32'd4);
        check_eq("add_cin_sum", r_sum[0], 32'd8);

        run_one(1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001);
        check_eq("add_ovf_sum",  r_sum[0],     32'h80000000);
        check_eq("add_ovf_ovf",  32'(r_of[0]), 1);
        check_eq("add_ovf_cout", 32'(r_co[0]), 0);

        run_one(1'b1, 1'b0, 32'd5, 32'd9);
        check_eq("sub_5_9_sum",  r_sum[0],     32'hFFFFFFFC);
        check_eq("sub_5_9_cout", 32'(r_co[0]), 0);
        check_eq("sub_5_9_lt",   32'(r_lt[0]), 1);
        check_eq("sub_5_9_ne",   32'(r_ne[0]), 1);
        check_eq("sub_5_9_ovf",  32'(r_of[0]), 0);

        run_one(1'b1, 1'b1, 32'h12345678, 32'h12345678);
        check_eq("sub_eq_sum",  r_sum[0],     0);
        check_eq("sub_eq_cout", 32'(r_co[0]), 1);
        check_eq("sub_eq_ne",   32'(r_ne[0]), 0);
        check_eq("sub_eq_lt",   32'(r_lt[0]), 0);

        run_one(1'b1, 1'b0, 32'h80000000, 32'h00000001);
        check_eq("sub_min_sum",  r_sum[0],     32'h7FFFFFFF);
        check_eq("sub_min_ovf",  32'(r_of[0]), 1);
        check_eq("sub_min_lt",   32'(r_lt[0]), 1);
        check_eq("sub_min_cout", 32'(r_co[0]), 1);

`ifdef CSA_SATURATE_EN
        sat_en = 1'b1;
        run_one(1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001);
        check_eq("sat_pos_sum", r_sum[0],     32'h7FFFFFFF);
        check_eq("sat_pos_ovf", 32'(r_of[0]), 1);
        run_one(1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF);
        check_eq("sat_neg_sum",  r_sum[0],     32'h80000000);
        check_eq("sat_neg_cout", 32'(r_co[0]), 1);
        run_one(1'b1, 1'b0, 32'h80000000, 32'h00000001);
        check_eq("sat_sub_sum", r_sum[0],     32'h80000000);
        check_eq("sat_sub_ne",  32'(r_ne[0]), 1);
        check_eq("sat_sub_lt",  32'(r_lt[0]), 1);
        run_one(1'b0, 1'b0, 32'd3, 32'd4);
        check_eq("sat_noovf_sum", r_sum[0], 32'd7);
        sat_en = 1'b0;
`endif

        idx  = 0;
        ridx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            cin       = 1'b0;
            if (idx < 4) begin
                in_valid = 1'b1;
                op_sub   = st_sub[idx];
                data_a   = st_a[idx];
                data_b   = st_b[idx];
            end else begin
                in_valid = 1'b0;
                data_a   = 'x;
                data_b   = 'x;
            end
            @(negedge clock);
            if (cyc == 2) check_eq("stream_in_ready_full", 32'(rdy[0]), 0);
            if (cyc == 5) check_eq("stream_in_ready_back", 32'(rdy[0]), 1);
            if (ov[0]) begin
                if (ridx < 4) check_eq($sformatf("stream_res%0d", ridx), sm[0], st_exp[ridx]);
                else          check_eq("stream_extra", 32'(ov[0]), 0);
                if (out_ready) ridx++;
            end
            if (in_valid && rdy[0]) idx++;
            @(posedge clock); #1;
        end
        check_eq("stream_count", ridx, 4);
        check_eq("stream_accepted", idx, 4);

        op_sub   = 1'b0;
        in_valid = 1'b1;
        data_a   = 32'd1;
        data_b   = 32'd1;
        @(posedge clock); #1;
        data_a   = 32'd2;
        data_b   = 32'd2;
        @(posedge clock); #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clock); #1;
        reset    = 1'b0;
        check_eq("midrst_out_valid", 32'(ov[0]), 0);
        check_eq("midrst_sum",       sm[0],      0);
        check_eq("midrst_cout",      32'(co[0]), 0);
        check_eq("midrst_in_ready",  32'(rdy[0]), 1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            check_eq("midrst_no_output", 32'(ov[0]), 0);
        end
        run_one(1'b0, 1'b0, 32'h00001234, 32'h00001111);
        check_eq("postrst_sum", r_sum[0], 32'h00002345);
        check_eq("postrst_lat", lat[0],   2);

        run_one(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000);
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("wrap_sum_dut%0d", d),  r_sum[d],     0);
            check_eq($sformatf("wrap_cout_dut%0d", d), 32'(r_co[d]), 1);
            check_eq($sformatf("wrap_ovf_dut%0d", d),  32'(r_of[d]), 0);
        end
        check_eq("wrap_lat_s2", lat[0], 2);
        check_eq("wrap_lat_s1", lat[1], 1);
        check_eq("wrap_lat_s4", lat[2], 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
